// File: rtl/light_scheduler_pkg.sv
// Shared lamp colours, FSM state encoding and phase helper for the light scheduler.
// Pure definitions: no latency, no backpressure.
package light_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5,
    WALK  = 3'd6
  } state_t;

  // Green that follows the all-red clearance (and any walk phase inside it).
  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

  function automatic logic [2:0] phase_of(input state_t s);
    return 3'(s);
  endfunction

endpackage

// File: rtl/light_scheduler_if.sv
// Street sensors, pedestrian button and lamp outputs of the light scheduler.
// Wires only: no latency, no backpressure.
interface light_scheduler_if;
  logic       ta;
  logic       tb;
  logic       m;
  logic       ped_req;
  logic [2:0] la;
  logic [2:0] lb;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (output ta, tb, m, ped_req,
                  input  la, lb, walk, ped_pending, phase);
  modport slave  (input  ta, tb, m, ped_req,
                  output la, lb, walk, ped_pending, phase);
endinterface

// File: rtl/light_scheduler_phase_timer.sv
// Phase timer: clears on clr, otherwise counts up and saturates at all-ones.
// Value updates one cycle after clr; never stalls.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  output logic [CNT_W-1:0] t
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      t <= '0;
    else if (clr)
      t <= '0;
    else if (t != '1)
      t <= t + 1'b1;
  end

endmodule

// File: rtl/light_scheduler.sv
// Two-street traffic light scheduler with pedestrian walk phase and parade hold on B.
// Moore lamps from registered state; requests latched in one cycle; free-running, no backpressure.
module light_scheduler
  import light_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 40,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 12
) (
  input logic               clk,
  input logic               reset_n,
  light_scheduler_if.slave  bus
);

  localparam longint LIMIT = longint'(1) << CNT_W;

  if (CNT_W < 1 || CNT_W > 31 ||
      GREEN_MIN < 1 || longint'(GREEN_MIN) >= LIMIT ||
      GREEN_MAX < 1 || longint'(GREEN_MAX) >= LIMIT ||
      YELLOW_T  < 1 || longint'(YELLOW_T)  >= LIMIT ||
      ALLRED_T  < 1 || longint'(ALLRED_T)  >= LIMIT ||
      WALK_T    < 1 || longint'(WALK_T)    >= LIMIT ||
      GREEN_MAX <= GREEN_MIN) begin : g_bad_params
    $error("light_scheduler: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ARED_M1 = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] t;
  logic             next_dir_q;
  logic             ped_q;
  logic             walk_done;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_d != state_q),
    .t       (t)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= A_GRN;
    else
      state_q <= state_d;
  end

  assign walk_done = (state_q == WALK) && (t == WALK_M1);

  always_comb begin
    state_d         = state_q;
    bus.la          = RED;
    bus.lb          = RED;
    bus.walk        = 1'b0;
    bus.phase       = phase_of(state_q);
    bus.ped_pending = ped_q;
    case (state_q)
      A_GRN: begin
        bus.la = GREEN;
        if (t >= GMIN_M1 && (!bus.ta || ped_q || (bus.tb && t >= GMAX_M1)))
          state_d = A_YEL;
      end
      A_YEL: begin
        bus.la = YELLOW;
        if (t == YEL_M1) state_d = AR_AB;
      end
      AR_AB: if (t == ARED_M1) state_d = ped_q ? WALK : B_GRN;
      B_GRN: begin
        bus.lb = GREEN;
        // Parade mode pins B green indefinitely, overriding max-green and pedestrians.
        if (!bus.m && t >= GMIN_M1 && (!bus.tb || ped_q || (bus.ta && t >= GMAX_M1)))
          state_d = B_YEL;
      end
      B_YEL: begin
        bus.lb = YELLOW;
        if (t == YEL_M1) state_d = AR_BA;
      end
      AR_BA: if (t == ARED_M1) state_d = ped_q ? WALK : A_GRN;
      WALK: begin
        bus.walk = 1'b1;
        if (walk_done) state_d = (next_dir_q == DIR_B) ? B_GRN : A_GRN;
      end
      default: state_d = A_GRN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      next_dir_q <= DIR_B;
    else if (state_d == AR_AB)
      next_dir_q <= DIR_B;
    else if (state_d == AR_BA)
      next_dir_q <= DIR_A;
  end

  // A new press on the walk exit cycle keeps the request alive for the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ped_q <= 1'b0;
    else if (bus.ped_req)
      ped_q <= 1'b1;
    else if (walk_done)
      ped_q <= 1'b0;
  end

endmodule

// File: tb/tb_light_scheduler.sv
// Directed bench for light_scheduler: timing of each phase, pedestrian, parade and reset cases.
// Inputs change #1 after the rising edge; outputs are checked at that same point.
module tb_light_scheduler;
  import light_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  light_scheduler_if bus();

  light_scheduler #(
    .CNT_W(8), .GREEN_MIN(10), .GREEN_MAX(40),
    .YELLOW_T(4), .ALLRED_T(2), .WALK_T(12)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] la_for(input int p);
    case (p)
      0:       return GREEN;
      1:       return YELLOW;
      default: return RED;
    endcase
  endfunction

  function automatic logic [2:0] lb_for(input int p);
    case (p)
      3:       return GREEN;
      4:       return YELLOW;
      default: return RED;
    endcase
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: reset just released, first edge still ahead.
  task automatic start(input logic a, input logic b, input logic mm);
    reset_n     = 1'b0;
    bus.ta      = a;
    bus.tb      = b;
    bus.m       = mm;
    bus.ped_req = 1'b0;
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    bus.ta      = 1'b1;
    bus.tb      = 1'b1;
    bus.m       = 1'b0;
    bus.ped_req = 1'b1;
    next_cycle();
    next_cycle();
    total++; if (bus.phase !== 3'd0) begin bad++; $display("FAIL rst_phase got=%0d want=0", bus.phase); end
    total++; if (bus.la !== GREEN) begin bad++; $display("FAIL rst_la got=%b want=%b", bus.la, GREEN); end
    total++; if (bus.lb !== RED) begin bad++; $display("FAIL rst_lb got=%b want=%b", bus.lb, RED); end
    total++; if (bus.walk !== 1'b0) begin bad++; $display("FAIL rst_walk got=%b want=0", bus.walk); end
    total++; if (bus.ped_pending !== 1'b0) begin bad++; $display("FAIL rst_ped got=%b want=0", bus.ped_pending); end
    bus.ped_req = 1'b0;
    reset_n = 1'b1;
    next_cycle();
    total++; if (bus.phase !== 3'd0) begin bad++; $display("FAIL rst_rel_phase got=%0d want=0", bus.phase); end
    total++; if (bus.ped_pending !== 1'b0) begin bad++; $display("FAIL rst_rel_ped got=%b want=0", bus.ped_pending); end
  endtask

  task automatic test_a_hold;
    start(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 200; c++) begin
      total++; if (bus.phase !== 3'd0) begin bad++; $display("FAIL hold_phase c=%0d got=%0d want=0", c, bus.phase); end
      total++; if (bus.la !== GREEN) begin bad++; $display("FAIL hold_la c=%0d got=%b want=%b", c, bus.la, GREEN); end
      next_cycle();
    end
  endtask

  task automatic test_a_to_b;
    int e;
    start(1'b0, 1'b1, 1'b0);
    for (int c = 0; c <= 20; c++) begin
      e = (c <= 9) ? 0 : (c <= 13) ? 1 : (c <= 15) ? 2 : 3;
      total++; if (bus.phase !== 3'(e)) begin bad++; $display("FAIL a2b_phase c=%0d got=%0d want=%0d", c, bus.phase, e); end
      total++; if (bus.la !== la_for(e)) begin bad++; $display("FAIL a2b_la c=%0d got=%b want=%b", c, bus.la, la_for(e)); end
      total++; if (bus.lb !== lb_for(e)) begin bad++; $display("FAIL a2b_lb c=%0d got=%b want=%b", c, bus.lb, lb_for(e)); end
      next_cycle();
    end
  endtask

  task automatic test_green_max;
    int e;
    int r;
    start(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 190; c++) begin
      r = c % 92;
      e = (r < 40) ? 0 : (r < 44) ? 1 : (r < 46) ? 2 : (r < 86) ? 3 : (r < 90) ? 4 : 5;
      total++; if (bus.phase !== 3'(e)) begin bad++; $display("FAIL max_phase c=%0d got=%0d want=%0d", c, bus.phase, e); end
      next_cycle();
    end
  endtask

  task automatic test_ped;
    int e;
    start(1'b0, 1'b1, 1'b0);
    for (int c = 0; c <= 58; c++) begin
      e = (c <= 9) ? 0 : (c <= 13) ? 1 : (c <= 15) ? 2 : (c <= 37) ? 3 :
          (c <= 41) ? 4 : (c <= 43) ? 5 : (c <= 55) ? 6 : 0;
      total++; if (bus.phase !== 3'(e)) begin bad++; $display("FAIL ped_phase c=%0d got=%0d want=%0d", c, bus.phase, e); end
      total++; if (bus.ped_pending !== (c >= 37 && c <= 55)) begin bad++; $display("FAIL ped_pend c=%0d got=%b", c, bus.ped_pending); end
      total++; if (bus.walk !== (e == 6)) begin bad++; $display("FAIL ped_walk c=%0d got=%b want=%b", c, bus.walk, e == 6); end
      total++; if (bus.la !== la_for(e) || bus.lb !== lb_for(e)) begin bad++; $display("FAIL ped_lamps c=%0d got=%b/%b want=%b/%b", c, bus.la, bus.lb, la_for(e), lb_for(e)); end
      bus.ped_req = (c == 36);
      next_cycle();
    end
  endtask

  task automatic test_parade;
    int e;
    start(1'b0, 1'b1, 1'b0);
    for (int c = 0; c <= 150; c++) begin
      e = (c <= 9) ? 0 : (c <= 13) ? 1 : (c <= 15) ? 2 : (c <= 115) ? 3 :
          (c <= 119) ? 4 : (c <= 121) ? 5 : (c <= 133) ? 6 : (c <= 143) ? 0 :
          (c <= 147) ? 1 : (c <= 149) ? 2 : 6;
      total++; if (bus.phase !== 3'(e)) begin bad++; $display("FAIL par_phase c=%0d got=%0d want=%0d", c, bus.phase, e); end
      total++; if (bus.ped_pending !== (c >= 21)) begin bad++; $display("FAIL par_pend c=%0d got=%b want=%b", c, bus.ped_pending, c >= 21); end
      bus.ta      = (c >= 10);
      bus.m       = (c >= 10 && c <= 114) || (c >= 116 && c <= 118);
      bus.ped_req = (c == 20) || (c == 133);
      next_cycle();
    end
    bus.m = 1'b0;
    bus.ped_req = 1'b0;
  endtask

  task automatic test_reset_walk;
    int e;
    start(1'b0, 1'b1, 1'b0);
    for (int c = 0; c <= 49; c++) begin
      e = (c <= 9) ? 0 : (c <= 13) ? 1 : (c <= 15) ? 2 : (c <= 37) ? 3 :
          (c <= 41) ? 4 : (c <= 43) ? 5 : 6;
      total++; if (bus.phase !== 3'(e)) begin bad++; $display("FAIL rw_phase c=%0d got=%0d want=%0d", c, bus.phase, e); end
      if (c < 49) begin
        bus.ped_req = (c == 36);
        next_cycle();
      end
    end
    reset_n = 1'b0;
    #1;
    total++; if (bus.walk !== 1'b0) begin bad++; $display("FAIL rw_walk got=%b want=0", bus.walk); end
    total++; if (bus.la !== GREEN) begin bad++; $display("FAIL rw_la got=%b want=%b", bus.la, GREEN); end
    total++; if (bus.lb !== RED) begin bad++; $display("FAIL rw_lb got=%b want=%b", bus.lb, RED); end
    total++; if (bus.ped_pending !== 1'b0) begin bad++; $display("FAIL rw_ped got=%b want=0", bus.ped_pending); end
    total++; if (bus.phase !== 3'd0) begin bad++; $display("FAIL rw_phase0 got=%0d want=0", bus.phase); end
    next_cycle();
    reset_n = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      e = (c <= 9) ? 0 : 1;
      total++; if (bus.phase !== 3'(e)) begin bad++; $display("FAIL rw_after c=%0d got=%0d want=%0d", c, bus.phase, e); end
      total++; if (bus.ped_pending !== 1'b0) begin bad++; $display("FAIL rw_after_ped c=%0d got=%b want=0", c, bus.ped_pending); end
      next_cycle();
    end
  endtask

  initial begin
    bus.ta      = 1'b0;
    bus.tb      = 1'b0;
    bus.m       = 1'b0;
    bus.ped_req = 1'b0;
    #2;
    test_reset();
    test_a_hold();
    test_a_to_b();
    test_green_max();
    test_ped();
    test_parade();
    test_reset_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/light_scheduler.md
LIGHT_SCHEDULER -- requirements
Module: light_scheduler

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the phase timer.
REQ-002 The block SHALL have parameter GREEN_MIN, default 10: minimum green duration in cycles.
REQ-003 The block SHALL have parameter GREEN_MAX, default 40: green duration after which a green is forced to end when cross traffic waits.
REQ-004 The block SHALL have parameter YELLOW_T, default 4: yellow duration in cycles.
REQ-005 The block SHALL have parameter ALLRED_T, default 2: all-red clearance duration in cycles.
REQ-006 The block SHALL have parameter WALK_T, default 12: pedestrian walk duration in cycles.
REQ-007 The block SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-008 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have ports ta and tb, input, 1 bit each: traffic present on street A and street B.
REQ-010 The block SHALL have port m, input, 1 bit: parade mode, holds B green.
REQ-011 The block SHALL have port ped_req, input, 1 bit: pedestrian request, sampled every cycle.
REQ-012 The block SHALL have ports la and lb, output, 3 bits each: one-hot lamps, RED=100, YELLOW=010, GREEN=001.
REQ-013 The block SHALL have port walk, output, 1 bit: walk lamp.
REQ-014 The block SHALL have port ped_pending, output, 1 bit: a pedestrian request is latched.
REQ-015 The block SHALL have port phase, output, 3 bits: encoding of the current state.

Function
REQ-016 The state machine SHALL have states A_GRN=0, A_YEL=1, AR_AB=2, B_GRN=3, B_YEL=4, AR_BA=5, WALK=6; phase SHALL equal the state encoding; code 7 SHALL go to A_GRN on the next cycle.
REQ-017 Outputs SHALL be Moore (from state only).
- A_GRN: la=GREEN, lb=RED.
- A_YEL: la=YELLOW, lb=RED.
- B_GRN: la=RED, lb=GREEN.
- B_YEL: la=RED, lb=YELLOW.
- AR_AB, AR_BA, WALK and code 7: la=RED, lb=RED.
- walk=1 only in WALK.
REQ-018 The timer SHALL clear to 0 on every state change and otherwise increment by 1, saturating at 2^CNT_W-1; "t" below is the timer value.
REQ-019 A_GRN SHALL go to A_YEL when t>=GREEN_MIN-1 and at least one of the following holds: ta=0; ped_pending=1; tb=1 with t>=GREEN_MAX-1. Otherwise it SHALL hold A_GRN.
REQ-020 B_GRN SHALL hold while m=1, with no maximum. When m=0, it SHALL go to B_YEL when t>=GREEN_MIN-1 and at least one of the following holds: tb=0; ped_pending=1; ta=1 with t>=GREEN_MAX-1.
REQ-021 A_YEL SHALL go to AR_AB, and B_YEL to AR_BA, at t==YELLOW_T-1; m and ped_req SHALL NOT alter this.
REQ-022 AR_AB/AR_BA SHALL exit at t==ALLRED_T-1: to WALK if ped_pending, else to B_GRN or A_GRN respectively.
REQ-023 A 1-bit next_dir register SHALL record the green to follow the clearance. WALK SHALL exit at t==WALK_T-1 to that green.
REQ-024 ped_pending SHALL set on any cycle with ped_req=1 and clear on the exit cycle of WALK. If ped_req=1 on that same cycle, set SHALL win and ped_pending SHALL stay 1.
REQ-025 Each parameter SHALL be >=1 and <2^CNT_W, with GREEN_MAX>GREEN_MIN; violation SHALL be an elaboration error.

Reset
REQ-026 While reset_n=0, the following SHALL hold, and the first phase SHALL start on the first clock after release:
- state=A_GRN, timer=0, ped_pending=0, next_dir=B.
- la=GREEN, lb=RED, walk=0, phase=0.
REQ-027 Reset asserted in any state, including mid-WALK or mid-yellow, SHALL take effect immediately and discard any pending request.

Structure
REQ-028 Package light_pkg SHALL hold the color constants, the state enum and the phase encoding.
REQ-029 Sub-module phase_timer (CNT_W-bit clear/increment/saturate counter) SHALL implement the timer; the FSM and request latch SHALL stay in light_scheduler.

Verification
REQ-030 Reset, ta=1, tb=0 for 200 cycles -> phase stays 0, la=GREEN throughout.
REQ-031 ta=0, tb=1 after reset:
- A_GRN for cycles 0-9, A_YEL for 10-13, AR_AB for 14-15.
- B_GRN, lb=GREEN, from cycle 16.
REQ-032 ta=1, tb=1, m=0 -> A_GRN exactly 40 cycles, yellow 4, all-red 2, then B_GRN 40 cycles, repeating.
REQ-033 1-cycle ped_req during B_GRN at t=20 with tb=1 and m=0:
- ped_pending=1 on the next cycle; B_YEL follows on that cycle.
- Then AR_BA 2 cycles, WALK 12 cycles with walk=1 and both lamps RED, then A_GRN with ped_pending=0.
REQ-034 m=1 in B_GRN with ta=1 and a ped_req -> B_GRN held 100 cycles. After m drops: B_YEL on the next cycle, then WALK.
REQ-035 reset_n pulsed low at WALK t=5 -> immediately walk=0, la=GREEN, ped_pending=0; after release, normal A_GRN timing.
